i2c_line_filter: RTL

I2C_LINE_FILTER -- requirements
Module: i2c_line_filter

---
 rtl/i2c_line_filter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2c_line_filter.sv
// i2c_line_filter
//   Debounces NCH raw I2C-style lines and derives bus conditions from the
//   debounced SCL/SDA pair.
//
//   Each raw line is brought into the gclk domain through a two-flop
//   synchronizer and then shifted into a WIN-deep sample window. A channel's
//   debounced level only flips once the whole window agrees on the opposite
//   value. A burst of disagreeing samples that dies out before filling the
//   window is reported as a rejected glitch.
//
// Parameters
//   NCH      number of filtered lines (2..16)
//   WIN      debounce window depth in gclk samples (2..32)
//   SCL_IDX  channel used as SCL for START/STOP detection
//   SDA_IDX  channel used as SDA for START/STOP detection
//   CW       width of the saturating glitch counter
//
// Ports
//   gclk        clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   din         raw asynchronous line levels
//   clr_cnt     synchronous clear of glitch_cnt (wins over an increment)
//   lvl         debounced level per channel
//   rise/fall   one-cycle pulse when lvl goes 0->1 / 1->0
//   glitch      one-cycle pulse per rejected glitch
//   start/stop  one-cycle pulse on an I2C START / STOP condition
//   busy        set by START, cleared by STOP
//   glitch_cnt  saturating count of cycles with at least one glitch pulse
module i2c_line_filter #(
  parameter int NCH     = 2,
  parameter int WIN     = 8,
  parameter int SCL_IDX = 0,
  parameter int SDA_IDX = 1,
  parameter int CW      = 8
) (
  input  logic           gclk,
  input  logic           rst,
  input  logic [NCH-1:0] din,
  input  logic           clr_cnt,
  output logic [NCH-1:0] lvl,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic [NCH-1:0] glitch,
  output logic           start,
  output logic           stop,
  output logic           busy,
  output logic [CW-1:0]  glitch_cnt
);

  logic [NCH-1:0]          sync_a;
  logic [NCH-1:0]          sync_b;
  logic [NCH-1:0][WIN-1:0] win;
  logic [NCH-1:0]          dirty;

  logic [NCH-1:0] toggle;
  logic [NCH-1:0] settle;
  logic [NCH-1:0] lvl_nxt;
  logic [NCH-1:0] rise_nxt;
  logic [NCH-1:0] fall_nxt;
  logic [NCH-1:0] glitch_nxt;
  logic [NCH-1:0] dirty_nxt;
  logic           scl_hold;
  logic           start_nxt;
  logic           stop_nxt;
  logic           busy_nxt;
  logic [CW-1:0]  cnt_nxt;

  // toggle: window unanimously disagrees with lvl, so the level flips.
  // settle: window unanimously agrees with lvl; if anything disturbed it
  //         since the last settle/toggle, that disturbance was a glitch.
  // Any mixed window marks the channel dirty.
  always_comb begin
    toggle     = '0;
    settle     = '0;
    lvl_nxt    = lvl;
    rise_nxt   = '0;
    fall_nxt   = '0;
    glitch_nxt = '0;
    dirty_nxt  = dirty;
    for (int ch = 0; ch < NCH; ch++) begin
      toggle[ch]     = lvl[ch] ? ~|win[ch] : &win[ch];
      settle[ch]     = lvl[ch] ? &win[ch] : ~|win[ch];
      lvl_nxt[ch]    = lvl[ch] ^ toggle[ch];
      rise_nxt[ch]   = toggle[ch] & ~lvl[ch];
      fall_nxt[ch]   = toggle[ch] & lvl[ch];
      glitch_nxt[ch] = settle[ch] & dirty[ch];
      dirty_nxt[ch]  = ~(toggle[ch] | settle[ch]);
    end

    // SCL must be high both before and after the SDA edge; an SCL edge in
    // the same cycle makes the condition ambiguous and it is dropped.
    scl_hold  = lvl[SCL_IDX] & lvl_nxt[SCL_IDX];
    start_nxt = fall_nxt[SDA_IDX] & scl_hold;
    stop_nxt  = rise_nxt[SDA_IDX] & scl_hold;

    busy_nxt = busy;
    if (start_nxt) begin
      busy_nxt = 1'b1;
    end else if (stop_nxt) begin
      busy_nxt = 1'b0;
    end

    // Counts cycles with any glitch pulse, not individual channels.
    cnt_nxt = glitch_cnt;
    if (clr_cnt) begin
      cnt_nxt = '0;
    end else if ((|glitch) && (glitch_cnt != {CW{1'b1}})) begin
      cnt_nxt = glitch_cnt + CW'(1);
    end
  end

  // Idle I2C lines are high, so everything resets to the released state.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      sync_a     <= '1;
      sync_b     <= '1;
      win        <= '1;
      lvl        <= '1;
      dirty      <= '0;
      rise       <= '0;
      fall       <= '0;
      glitch     <= '0;
      start      <= 1'b0;
      stop       <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
      for (int ch = 0; ch < NCH; ch++) begin
        win[ch] <= {win[ch][WIN-2:0], sync_b[ch]};
      end
      lvl        <= lvl_nxt;
      dirty      <= dirty_nxt;
      rise       <= rise_nxt;
      fall       <= fall_nxt;
      glitch     <= glitch_nxt;
      start      <= start_nxt;
      stop       <= stop_nxt;
      busy       <= busy_nxt;
      glitch_cnt <= cnt_nxt;
    end
  end

endmodule
